// File: rtl/mips_pkg.sv
// mips_pkg
//   Definitions shared by the instruction fetch stage and its stall monitor:
//   the PC width, the NOP encoding used for squashed or reset IF/ID slots,
//   the fetch FSM state encodings, the IF/ID pipeline register layout, and a
//   PC increment helper.
package mips_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] NOP = 32'h0000_0000;

    // Fetch FSM encodings. These are visible on the fetch_state debug port,
    // so they must stay fixed.
    localparam logic [1:0] BOOT  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] STALL = 2'b10;

    typedef struct packed {
        logic [PC_W-1:0] instr;
        logic [PC_W-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    // The sum wraps modulo 2^32.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stall_monitor.sv
// fetch_stall_monitor
//   Watches the fetch stage for stalls.
//   - A watchdog counts consecutive active cycles that have the PC held. The
//     count saturates at STALL_LIMIT. One cycle after the count reaches the
//     limit, a sticky timeout flag is set. Only reset clears that flag.
//   - Optional build macro FETCH_STALL_COUNTER_EN adds a saturating 16-bit
//     total of all stalled active cycles. When the macro is undefined, the
//     output is tied to zero and no counter flops exist.
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   active         1 = fetch FSM is in RUN or STALL
//   stall          1 = PC held this cycle (PC_WriteEn = 0)
//   stall_timeout  sticky watchdog flag
//   stall_cycles   total stalled-cycle count (zero when counter disabled)
module fetch_stall_monitor #(
    parameter int STALL_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        active,
    input  logic        stall,
    output logic        stall_timeout,
    output logic [15:0] stall_cycles
);

    localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

    logic [7:0] wd_cnt_q, wd_cnt_d;
    logic       timeout_q, timeout_d;

    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        // The flag is evaluated from the registered count. This gives the
        // one-cycle delay after the count reaches the limit.
        timeout_d = timeout_q | (wd_cnt_q >= LIMIT);
        if (active) begin
            if (!stall) begin
                wd_cnt_d = 8'd0;
            end else if (wd_cnt_q < LIMIT) begin
                wd_cnt_d = wd_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt_q  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_timeout = timeout_q;

`ifdef FETCH_STALL_COUNTER_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (active && stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction fetch stage. Holds the PC and the IF/ID pipeline register.
//   It obeys the enables from the hazard unit and the redirects from the ID
//   stage. A stall monitor sub-module adds a watchdog and an optional stall
//   counter.
//   Optional build macro: FETCH_STALL_COUNTER_EN. It enables the stall_cycles
//   counter. Without it, stall_cycles reads 0.
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   PC_WriteEn      PC update enable
//   IFID_WriteEn    IF/ID register update enable
//   branch_taken    redirect request from ID
//   branch_target   redirect address
//   imem_rdata      instruction at imem_addr (combinational memory)
//   imem_addr       current PC
//   IFID_Instr      registered instruction
//   IFID_PCplus4    registered PC+4
//   IFID_Valid      1 = IFID_Instr is a real instruction
//   fetch_state     FSM state (debug)
//   stall_timeout   sticky watchdog flag
//   stall_cycles    total stalled-cycle count
//
// state | meaning
// BOOT  | first cycle after reset; PC and IF/ID hold, nothing fetched
// RUN   | normal fetch
// STALL | both enables were low; left once both are high again
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          STALL_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PC_WriteEn,
    input  logic        IFID_WriteEn,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] IFID_Instr,
    output logic [31:0] IFID_PCplus4,
    output logic        IFID_Valid,
    output logic [1:0]  fetch_state,
    output logic        stall_timeout,
    output logic [15:0] stall_cycles
);

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    ifid_t           ifid_q, ifid_d;
    logic [PC_W-1:0] pc_plus4;
    logic            active;

    assign pc_plus4 = pc_inc(pc_q);
    assign active   = (state_q == RUN) || (state_q == STALL);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (!PC_WriteEn && !IFID_WriteEn) state_d = STALL;
            STALL:   if (PC_WriteEn && IFID_WriteEn)   state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // A hold enable takes priority over a redirect. A redirect that arrives
    // during a stall is therefore dropped, and the ID stage must present it
    // again.
    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        if (active) begin
            if (PC_WriteEn) begin
                pc_d = branch_taken ? branch_target : pc_plus4;
            end
            if (IFID_WriteEn) begin
                if (branch_taken) begin
                    ifid_d.instr    = NOP;
                    ifid_d.pc_plus4 = '0;
                    ifid_d.valid    = 1'b0;
                end else begin
                    ifid_d.instr    = imem_rdata;
                    ifid_d.pc_plus4 = pc_plus4;
                    ifid_d.valid    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= BOOT;
            pc_q            <= RESET_PC;
            ifid_q.instr    <= NOP;
            ifid_q.pc_plus4 <= '0;
            ifid_q.valid    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
        end
    end

    fetch_stall_monitor #(
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall_monitor (
        .clk           (clk),
        .rst_n         (rst_n),
        .active        (active),
        .stall         (!PC_WriteEn),
        .stall_timeout (stall_timeout),
        .stall_cycles  (stall_cycles)
    );

    assign imem_addr    = pc_q;
    assign IFID_Instr   = ifid_q.instr;
    assign IFID_PCplus4 = ifid_q.pc_plus4;
    assign IFID_Valid   = ifid_q.valid;
    assign fetch_state  = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Drives two fetch_stage instances with the same inputs:
//     dut0: default parameters (RESET_PC = 0, STALL_LIMIT = 4)
//     dut1: RESET_PC = 32'hFFFF_FFFC, STALL_LIMIT = 3, to exercise wrap-around
//   Each instance has its own combinational instruction memory, a fixed hash
//   of the address. A pipeline-level reference model predicts every output
//   after each rising edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_we, ifid_we, bt;
    logic [31:0] target;

    logic [31:0] addr  [2];
    logic [31:0] rdata [2];
    logic [31:0] instr [2];
    logic [31:0] p4    [2];
    logic        valid [2];
    logic [1:0]  fstate[2];
    logic        tmo   [2];
    logic [15:0] scyc  [2];

    int checks = 0;
    int errors = 0;

`ifdef FETCH_STALL_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [31:0] RPC [2] = '{32'h0000_0000, 32'hFFFF_FFFC};
    localparam int          LIM [2] = '{4, 3};

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_1234;
    endfunction

    assign rdata[0] = imem_word(addr[0]);
    assign rdata[1] = imem_word(addr[1]);

    fetch_stage #(.RESET_PC(32'h0000_0000), .STALL_LIMIT(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .PC_WriteEn(pc_we), .IFID_WriteEn(ifid_we),
        .branch_taken(bt), .branch_target(target), .imem_rdata(rdata[0]),
        .imem_addr(addr[0]), .IFID_Instr(instr[0]), .IFID_PCplus4(p4[0]),
        .IFID_Valid(valid[0]), .fetch_state(fstate[0]),
        .stall_timeout(tmo[0]), .stall_cycles(scyc[0]));

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .STALL_LIMIT(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .PC_WriteEn(pc_we), .IFID_WriteEn(ifid_we),
        .branch_taken(bt), .branch_target(target), .imem_rdata(rdata[1]),
        .imem_addr(addr[1]), .IFID_Instr(instr[1]), .IFID_PCplus4(p4[1]),
        .IFID_Valid(valid[1]), .fetch_state(fstate[1]),
        .stall_timeout(tmo[1]), .stall_cycles(scyc[1]));

    // Reference model state
    bit          m_boot;
    bit          m_stalled;
    logic [31:0] m_pc    [2];
    logic [31:0] m_instr [2];
    logic [31:0] m_p4    [2];
    bit          m_valid [2];
    int          m_run   [2];
    bit          m_to    [2];
    int          m_total [2];

    task automatic model_edge();
        logic [31:0] old_pc;
        if (!rst_n) begin
            m_boot    = 1'b1;
            m_stalled = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_pc[i] = RPC[i]; m_instr[i] = 32'h0; m_p4[i] = 32'h0;
                m_valid[i] = 1'b0; m_run[i] = 0; m_to[i] = 1'b0; m_total[i] = 0;
            end
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                old_pc = m_pc[i];
                if (ifid_we) begin
                    if (bt) begin
                        m_instr[i] = 32'h0; m_p4[i] = 32'h0; m_valid[i] = 1'b0;
                    end else begin
                        m_instr[i] = imem_word(old_pc);
                        m_p4[i]    = old_pc + 32'd4;
                        m_valid[i] = 1'b1;
                    end
                end
                if (pc_we) m_pc[i] = bt ? target : old_pc + 32'd4;
                if (m_run[i] >= LIM[i]) m_to[i] = 1'b1;
                if (pc_we) m_run[i] = 0;
                else       m_run[i] = (m_run[i] + 1 > LIM[i]) ? LIM[i] : m_run[i] + 1;
                if (CNT_EN && !pc_we && m_total[i] < 65535) m_total[i]++;
            end
            if (!pc_we && !ifid_we) m_stalled = 1'b1;
            else if (pc_we && ifid_we) m_stalled = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [1:0] exp_state;
        exp_state = m_boot ? 2'b00 : (m_stalled ? 2'b10 : 2'b01);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d.imem_addr", i),    addr[i],          m_pc[i]);
            chk($sformatf("dut%0d.IFID_Instr", i),   instr[i],         m_instr[i]);
            chk($sformatf("dut%0d.IFID_PCplus4", i), p4[i],            m_p4[i]);
            chk($sformatf("dut%0d.IFID_Valid", i),   32'(valid[i]),    32'(m_valid[i]));
            chk($sformatf("dut%0d.fetch_state", i),  32'(fstate[i]),   32'(exp_state));
            chk($sformatf("dut%0d.stall_timeout", i), 32'(tmo[i]),     32'(m_to[i]));
            chk($sformatf("dut%0d.stall_cycles", i), 32'(scyc[i]),     32'(m_total[i]));
        end
    endtask

    task automatic cycle(input bit r, input bit pw, input bit iw, input bit b,
                         input logic [31:0] t);
        rst_n = r; pc_we = pw; ifid_we = iw; bt = b; target = t;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    int burst;

    initial begin
        rst_n = 1'b0; pc_we = 1'b1; ifid_we = 1'b1; bt = 1'b0; target = 32'h0;
        m_boot = 1'b1; m_stalled = 1'b0;

        // Reset, then a straight-line fetch
        cycle(0, 1, 1, 0, 32'h0);
        cycle(0, 1, 1, 0, 32'h0);
        chk("reset.addr0", addr[0], 32'h0000_0000);
        chk("reset.addr1", addr[1], 32'hFFFF_FFFC);
        cycle(1, 1, 1, 0, 32'h0);             // BOOT -> RUN
        chk("boot.valid0", 32'(valid[0]), 32'h0);
        cycle(1, 1, 1, 0, 32'h0);
        chk("run.addr0", addr[0], 32'h4);
        chk("run.p4_0", p4[0], 32'h4);
        chk("wrap.addr1", addr[1], 32'h0);
        chk("wrap.p4_1", p4[1], 32'h0);
        cycle(1, 1, 1, 0, 32'h0);             // PC = 8

        // Load-use stall at PC = 8
        cycle(1, 0, 0, 0, 32'h0);
        chk("stall.state0", 32'(fstate[0]), 32'h2);
        chk("stall.addr0", addr[0], 32'h8);
        cycle(1, 1, 1, 0, 32'h0);
        cycle(1, 1, 1, 0, 32'h0);

        // Redirect, then a redirect that is blocked by PC_WriteEn = 0
        cycle(1, 1, 1, 1, 32'h100);
        chk("branch.addr0", addr[0], 32'h100);
        chk("branch.valid0", 32'(valid[0]), 32'h0);
        cycle(1, 1, 1, 0, 32'h0);
        cycle(1, 0, 1, 1, 32'h200);
        cycle(1, 1, 0, 0, 32'h0);             // mismatched enables the other way

        // Five-cycle PC stall, then release
        for (int k = 0; k < 5; k++) cycle(1, 0, 0, 0, 32'h0);
        chk("wd.tmo0", 32'(tmo[0]), 32'h1);
        cycle(1, 1, 1, 0, 32'h0);
        cycle(1, 1, 1, 0, 32'h0);
        chk("wd.sticky0", 32'(tmo[0]), 32'h1);

        // Reset in the middle of a stall
        cycle(1, 0, 0, 0, 32'h0);
        cycle(0, 0, 0, 1, 32'h300);
        chk("rst.tmo0", 32'(tmo[0]), 32'h0);
        cycle(1, 1, 1, 0, 32'h0);

        // Randomized traffic with stall bursts and occasional resets
        burst = 0;
        for (int n = 0; n < 1500; n++) begin
            bit r, pw, iw, b;
            r = ($urandom_range(0, 199) != 0);
            if (burst == 0 && $urandom_range(0, 19) == 0) burst = $urandom_range(2, 7);
            if (burst > 0) begin
                pw = 1'b0;
                iw = ($urandom_range(0, 3) == 0);
                burst--;
            end else begin
                pw = ($urandom_range(0, 4) != 0);
                iw = ($urandom_range(0, 4) != 0);
            end
            b = ($urandom_range(0, 5) == 0);
            cycle(r, pw, iw, b, $urandom() & 32'hFFFF_FFFC);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
